// File: rtl/time_disp_scan.sv
// time_disp_scan: six-digit multiplexed 7-segment scanner for a MM.SS.hh
// display. A prescaler sets the slot period. Each slot starts with a short
// blank phase that suppresses ghosting. Digit values are taken from shadow
// registers, which are reloaded once per frame.
module time_disp_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  input  logic       blank_lz_i,
  output logic [7:0] an_o,
  output logic [7:0] seg_o,
  output logic       frame_o
);

  localparam logic [15:0] LP_TC  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] LP_BLK = 16'(BLANK_CYC);

  logic [15:0] r_presc;
  logic [2:0]  r_idx;
  logic [7:0]  r_min;
  logic [7:0]  r_sec;
  logic [7:0]  r_ms;
  logic [7:0]  r_an;
  logic [7:0]  r_seg;
  logic        r_frame;

  logic        w_tick;
  logic        w_last;
  logic [3:0]  w_nib;
  logic [6:0]  w_dec;
  logic        w_dp;
  logic        w_blank;
  logic [7:0]  w_an_nxt;
  logic [7:0]  w_seg_nxt;

  assign w_tick = (r_presc == LP_TC);
  assign w_last = w_tick && (r_idx == 3'd5);

  // Pick the BCD nibble belonging to the current slot, then decode it
  // (active-low segments, dash for non-BCD).
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      3'd0:    w_nib = r_ms[3:0];
      3'd1:    w_nib = r_ms[7:4];
      3'd2:    w_nib = r_sec[3:0];
      3'd3:    w_nib = r_sec[7:4];
      3'd4:    w_nib = r_min[3:0];
      3'd5:    w_nib = r_min[7:4];
      default: w_nib = 4'h0;
    endcase
    w_dec = 7'h3F;
    case (w_nib)
      4'd0:    w_dec = 7'h40;
      4'd1:    w_dec = 7'h79;
      4'd2:    w_dec = 7'h24;
      4'd3:    w_dec = 7'h30;
      4'd4:    w_dec = 7'h19;
      4'd5:    w_dec = 7'h12;
      4'd6:    w_dec = 7'h02;
      4'd7:    w_dec = 7'h78;
      4'd8:    w_dec = 7'h00;
      4'd9:    w_dec = 7'h10;
      default: w_dec = 7'h3F;
    endcase
  end

  // Next anode/segment drive: blank phase and leading-zero suppression
  // override the active digit. blank_lz_i is used live, not shadowed.
  always_comb begin
    w_dp      = !((r_idx == 3'd2) || (r_idx == 3'd4));
    w_blank   = (r_presc < LP_BLK) ||
                ((r_idx == 3'd5) && blank_lz_i && (r_min[7:4] == 4'h0));
    w_an_nxt  = 8'hFF;
    w_seg_nxt = 8'hFF;
    if (!w_blank) begin
      w_an_nxt  = {2'b11, ~(6'b000001 << r_idx)};
      w_seg_nxt = {w_dp, w_dec};
    end
  end

  // Prescaler, slot index, per-frame shadow capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_ms    <= '0;
      r_an    <= 8'hFF;
      r_seg   <= 8'hFF;
      r_frame <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_tick) begin
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_last) begin
        r_min <= min_i;
        r_sec <= sec_i;
        r_ms  <= ms_10_i;
      end
      r_frame <= w_last;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_time_disp_scan.sv
// Directed bench for time_disp_scan with SCAN_DIV=4, BLANK_CYC=1.
// After the k-th rising edge following reset release, the outputs show slot
// (k%24)/4 at prescaler phase k%4. Phase 0 is the blank phase.
module tb_time_disp_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] min_i, sec_i, ms_10_i;
  logic       blank_lz_i;
  logic [7:0] an_o, seg_o;
  logic       frame_o;

  int checks = 0;
  int errors = 0;
  int k_now  = -1;

  time_disp_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .min_i      (min_i),
    .sec_i      (sec_i),
    .ms_10_i    (ms_10_i),
    .blank_lz_i (blank_lz_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_k(input int k);
    adv(k - k_now);
    k_now = k;
  endtask

  task automatic chk_disp(input string tag, input int k, input logic [7:0] an_e,
                          input logic [7:0] seg_e);
    to_k(k);
    chk({tag, "_an"}, an_o, an_e);
    chk({tag, "_seg"}, seg_o, seg_e);
  endtask

  task automatic chk_frame(input string tag, input int k, input logic f_e);
    to_k(k);
    chk(tag, {7'd0, frame_o}, {7'd0, f_e});
  endtask

  initial begin
    rst        = 1'b0;
    min_i      = 8'h77;
    sec_i      = 8'h66;
    ms_10_i    = 8'h55;
    blank_lz_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      chk("rst_an", an_o, 8'hFF);
      chk("rst_seg", seg_o, 8'hFF);
      chk("rst_frame", {7'd0, frame_o}, 8'h00);
    end

    rst        = 1'b1;
    k_now      = -1;
    min_i      = 8'h12;
    sec_i      = 8'h34;
    ms_10_i    = 8'h56;
    blank_lz_i = 1'b0;

    chk_disp("f0_blank", 0, 8'hFF, 8'hFF);
    chk_disp("f0_s0", 1, 8'hFE, 8'hC0);
    chk_disp("f0_s5", 21, 8'hDF, 8'hC0);
    chk_frame("f0_nofrm", 22, 1'b0);
    chk_frame("f0_frm", 23, 1'b1);
    chk_frame("f0_frm_end", 24, 1'b0);
    chk_disp("f1_blank", 24, 8'hFF, 8'hFF);
    chk_disp("f1_s0", 25, 8'hFE, 8'h82);
    chk_disp("f1_s2", 33, 8'hFB, 8'h19);
    chk_disp("f1_s3_blank", 36, 8'hFF, 8'hFF);
    to_k(37);
    min_i   = 8'h99;
    sec_i   = 8'h99;
    ms_10_i = 8'h99;
    chk_disp("f1_s4", 41, 8'hEF, 8'h24);
    chk_disp("f1_s5", 45, 8'hDF, 8'hF9);
    chk_frame("f1_frm", 47, 1'b1);
    chk_disp("f2_s0", 49, 8'hFE, 8'h90);
    to_k(50);
    min_i      = 8'h05;
    sec_i      = 8'h00;
    ms_10_i    = 8'hA7;
    blank_lz_i = 1'b1;
    chk_disp("f2_s3", 61, 8'hF7, 8'h90);
    chk_disp("f3_s0", 73, 8'hFE, 8'hF8);
    chk_disp("f3_s1", 77, 8'hFD, 8'hBF);
    chk_disp("f3_s4", 89, 8'hEF, 8'h12);
    chk_disp("f3_s5_lz", 93, 8'hFF, 8'hFF);
    blank_lz_i = 1'b0;
    chk_disp("f3_s5_nolz", 94, 8'hDF, 8'hC0);

    to_k(109);
    rst = 1'b0;
    adv(1);
    chk("mid_rst_an", an_o, 8'hFF);
    chk("mid_rst_seg", seg_o, 8'hFF);
    chk("mid_rst_frame", {7'd0, frame_o}, 8'h00);
    rst   = 1'b1;
    k_now = -1;

    chk_disp("r_blank", 0, 8'hFF, 8'hFF);
    chk_disp("r_s0", 1, 8'hFE, 8'hC0);
    chk_disp("r_s1", 5, 8'hFD, 8'hC0);
    chk_frame("r_nofrm", 6, 1'b0);
    chk_disp("r_s4", 17, 8'hEF, 8'h40);
    chk_disp("r_s5", 21, 8'hDF, 8'hC0);
    chk_frame("r_nofrm2", 22, 1'b0);
    chk_frame("r_frm", 23, 1'b1);
    chk_disp("r_f1_s0", 25, 8'hFE, 8'hF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
